// File: rtl/reorder_buffer_if.sv
// Reorder buffer port bundle: issue-side allocation, CDB result broadcast,
// operand lookup, in-order commit and an occupancy debug view.
interface reorder_buffer_if #(
    parameter int data_width = 16,
    parameter int tag_width  = 3
);
    typedef struct packed {
        logic                  valid;
        logic [tag_width-1:0]  tag;
        logic [data_width-1:0] data;
    } cdb_t;

    // Handshakes: an alloc is accepted on a rising edge where alloc=1 and
    // full=0 (full acts as the inverse of ready); CDB_in and commit_valid
    // are single-cycle pulses with no back-pressure, always consumed.
    logic                  alloc;
    logic [2:0]            alloc_dest;
    logic [tag_width-1:0]  alloc_tag;
    logic                  full;
    logic                  empty;
    cdb_t                  CDB_in;
    logic [tag_width-1:0]  rd_tag_a;
    logic [tag_width-1:0]  rd_tag_b;
    logic                  rd_ready_a;
    logic                  rd_ready_b;
    logic [data_width-1:0] rd_data_a;
    logic [data_width-1:0] rd_data_b;
    logic                  commit_valid;
    logic [2:0]            commit_reg;
    logic [data_width-1:0] commit_data;
    logic [tag_width-1:0]  commit_tag;
    logic [tag_width:0]    count;

    modport master (
        output alloc, alloc_dest, CDB_in, rd_tag_a, rd_tag_b,
        input  alloc_tag, full, empty, rd_ready_a, rd_ready_b, rd_data_a,
               rd_data_b, commit_valid, commit_reg, commit_data, commit_tag, count
    );

    modport slave (
        input  alloc, alloc_dest, CDB_in, rd_tag_a, rd_tag_b,
        output alloc_tag, full, empty, rd_ready_a, rd_ready_b, rd_data_a,
               rd_data_b, commit_valid, commit_reg, commit_data, commit_tag, count
    );
endinterface

// File: rtl/reorder_buffer.sv
// Eight-entry reorder buffer: allocates in program order, accepts results
// out of order from the CDB, and retires the head entry once it is ready.
module reorder_buffer #(
    parameter int data_width = 16,
    parameter int tag_width  = 3
) (
    input logic             clk,
    input logic             flush,
    reorder_buffer_if.slave bus
);
    localparam int depth = 1 << tag_width;

    logic [depth-1:0]      valid_q;
    logic [depth-1:0]      ready_q;
    logic [2:0]            dest_q [depth];
    logic [data_width-1:0] data_q [depth];
    logic [tag_width-1:0]  head;
    logic [tag_width-1:0]  tail;
    logic [tag_width:0]    count;

    logic do_alloc;
    logic do_retire;
    logic do_cdb;
    logic hit_a;
    logic hit_b;

    // count never exceeds depth, so its top bit alone marks a full buffer
    assign bus.full      = count[tag_width];
    assign bus.empty     = (count == '0);
    assign bus.count     = count;
    assign bus.alloc_tag = tail;

    assign do_alloc  = bus.alloc && !bus.full;
    assign do_retire = valid_q[head] && ready_q[head];
    assign do_cdb    = bus.CDB_in.valid && valid_q[bus.CDB_in.tag]
                       && !(do_retire && (bus.CDB_in.tag == head));

    assign bus.commit_valid = do_retire;
    assign bus.commit_reg   = dest_q[head];
    assign bus.commit_data  = data_q[head];
    assign bus.commit_tag   = head;

    // A result on the CDB this cycle is forwarded straight to the lookup ports
    assign hit_a = bus.CDB_in.valid && (bus.CDB_in.tag == bus.rd_tag_a);
    assign hit_b = bus.CDB_in.valid && (bus.CDB_in.tag == bus.rd_tag_b);

    assign bus.rd_ready_a = valid_q[bus.rd_tag_a] && (ready_q[bus.rd_tag_a] || hit_a);
    assign bus.rd_ready_b = valid_q[bus.rd_tag_b] && (ready_q[bus.rd_tag_b] || hit_b);
    assign bus.rd_data_a  = hit_a ? bus.CDB_in.data : data_q[bus.rd_tag_a];
    assign bus.rd_data_b  = hit_b ? bus.CDB_in.data : data_q[bus.rd_tag_b];

    always_ff @(posedge clk) begin
        if (flush) begin
            valid_q <= '0;
            ready_q <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            if (do_retire) begin
                valid_q[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            if (do_alloc) begin
                valid_q[tail] <= 1'b1;
                ready_q[tail] <= 1'b0;
                tail          <= tail + 1'b1;
            end
            if (do_cdb) begin
                ready_q[bus.CDB_in.tag] <= 1'b1;
            end
            case ({do_alloc, do_retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; valid/ready gate every use of it
    always_ff @(posedge clk) begin
        if (!flush && do_alloc) begin
            dest_q[tail] <= bus.alloc_dest;
        end
        if (!flush && do_cdb) begin
            data_q[bus.CDB_in.tag] <= bus.CDB_in.data;
        end
    end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameters: data_width, 16, operand/result width; tag_width, 3, CDB tag width; depth fixed at 2**tag_width (8) entries.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 flush  in  1  synchronous active-high reset; also used as mispredict flush.
REQ-004 alloc  in  1  issue stage requests a new entry this cycle.
REQ-005 alloc_dest  in  3  architectural destination register of the allocating instruction.
REQ-006 CDB_in  in  CDB  result broadcast from the RS units; fields used: valid, tag, data.
REQ-007 rd_tag_a, rd_tag_b  in  tag_width  operand lookup tags from issue stage.
REQ-008 alloc_tag  out  tag_width  tag that an accepted alloc receives (current tail index).
REQ-009 full, empty  out  1  occupancy flags.
REQ-010 rd_ready_a, rd_ready_b  out  1  looked-up entry holds a valid result.
REQ-011 rd_data_a, rd_data_b  out  data_width  looked-up result value.
REQ-012 commit_valid  out  1  head entry retires at the next edge.
REQ-013 commit_reg  out  3; commit_data  out  data_width; commit_tag  out  tag_width  retiring entry contents.

Function
REQ-014 Each entry SHALL hold valid, ready, dest[2:0], data[data_width-1:0].
REQ-015 head and tail SHALL be tag_width-bit pointers wrapping 7->0; count SHALL range 0..8.
REQ-016 full SHALL equal (count==8); empty SHALL equal (count==0); both combinational from registered count.
REQ-017 alloc with full=0 SHALL, at the edge: set entry[tail].valid=1, ready=0, dest=alloc_dest; tail+=1.
REQ-018 alloc with full=1 SHALL be ignored: no pointer, count, or entry change.
REQ-019 alloc_tag SHALL equal tail combinationally, regardless of alloc.
REQ-020 CDB_in.valid with entry[CDB_in.tag].valid=1 SHALL, at the edge: set ready=1, data=CDB_in.data.
REQ-021 CDB_in.valid targeting an invalid entry SHALL be ignored.
REQ-022 commit_valid SHALL equal entry[head].valid && entry[head].ready; commit_reg/data/tag SHALL reflect entry[head] and head combinationally.
REQ-023 When commit_valid=1, at the edge entry[head].valid SHALL clear and head SHALL increment; at most one retire per cycle.
REQ-024 Latency: CDB write at edge N SHALL allow commit_valid=1 in cycle N+1 if that entry is head.
REQ-025 Simultaneous accepted alloc and retire SHALL leave count unchanged; alloc only SHALL increment it; retire only SHALL decrement it.
REQ-026 full is evaluated before the edge: when full=1, alloc is rejected even if a retire occurs in the same cycle.
REQ-027 A CDB write and retire to the same entry in one cycle cannot conflict: retire requires ready=1 beforehand; the CDB write SHALL be ignored if the entry is retiring.
REQ-028 Read ports: rd_ready_x SHALL be entry[rd_tag_x].valid && (entry.ready || (CDB_in.valid && CDB_in.tag==rd_tag_x)).
REQ-029 Read ports: rd_data_x SHALL forward CDB_in.data on that bypass match; otherwise it SHALL be entry.data.
REQ-030 rd_ready_x SHALL be 0 for an invalid entry; rd_data_x is then don't-care.

Reset
REQ-031 flush=1 SHALL at the edge clear all valid and ready bits and set head=0, tail=0, count=0; flush overrides alloc, CDB write and retire in the same cycle.
REQ-032 After flush: empty=1, full=0, commit_valid=0, alloc_tag=0, rd_ready_a/b=0; data/dest contents are don't-care.

Verification
REQ-033 Flush, then alloc dest=3 -> alloc_tag=0 beforehand; next cycle empty=0, count=1, commit_valid=0.
REQ-034 Entry 0 allocated, CDB_in{valid=1,tag=0,data=16'hBEEF} -> next cycle commit_valid=1, commit_reg=3, commit_data=16'hBEEF; the following cycle empty=1.
REQ-035 9 allocs with no CDB traffic -> full=1 after 8; 9th rejected, tail wraps to 0, alloc_tag=0.
REQ-036 Full buffer, head ready, alloc asserted -> retire occurs, alloc rejected, count=7, full=0 next cycle.
REQ-037 Entries 2 and 0 complete out of order (tag 2 first) -> no commit until tag 0 ready; then tags 0, 1, 2 retire in order only as each becomes ready.
REQ-038 rd_tag_a=5, entry 5 valid and not ready, CDB tag 5 data=16'h0042 same cycle -> rd_ready_a=1, rd_data_a=16'h0042 combinationally; flush mid-occupancy -> all flags per REQ-032 next cycle.
